// File: rtl/morv_bus_pkg.sv
// Shared types and bus widths for the two-master memory bus arbiter.
// Pure declarations; no logic, no latency, no backpressure.
package morv_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int N_MST  = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef logic mst_idx_t;

endpackage

// File: rtl/morv_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the master not granted last wins, a lone requester always wins.
// Purely combinational, zero latency; never stalls, valid simply follows any request.
module morv_rr_arbiter2
   import morv_bus_pkg::*;
(
   input  logic [N_MST-1:0] req,
   input  logic             last,
   output logic             grant,
   output logic             valid
);

   always_comb begin
      valid = |req;
      grant = 1'b0;
      if (req == 2'b11)
         grant = ~last;
      else
         grant = req[1];
   end

endmodule

// File: rtl/morv_bus_arbiter.sv
// Shares one memory bus between CPU (0) and DMA/debug (1): 1 idle arbitration cycle, then BUSY until ready or timeout.
// Completion is same-cycle with ready; a silent slave is cut off after TIMEOUT BUSY cycles with an error pulse.
module morv_bus_arbiter
   import morv_bus_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MST-1:0]              m_req,
   input  logic [N_MST-1:0][ADDR_W-1:0]  m_address,
   input  logic [N_MST-1:0][DATA_W-1:0]  m_wdata,
   input  logic [N_MST-1:0]              m_write,
   input  logic [N_MST-1:0][STRB_W-1:0]  m_wstrb,
   output logic [N_MST-1:0][DATA_W-1:0]  m_rdata,
   output logic [N_MST-1:0]              m_ready,
   output logic [N_MST-1:0]              m_err,
   output logic                          s_valid,
   output logic [ADDR_W-1:0]             address,
   output logic [DATA_W-1:0]             wdata,
   output logic                          write,
   output logic [STRB_W-1:0]             wstrb,
   input  logic [DATA_W-1:0]             rdata,
   input  logic                          ready
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;

   state_t           state;
   mst_idx_t         grant_q;
   mst_idx_t         last_q;
   mst_idx_t         arb_grant;
   logic             arb_valid;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             timeout_hit;
   logic             done;

   morv_rr_arbiter2 u_rr (
      .req   (m_req),
      .last  (last_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   assign busy        = (state == BUSY);
   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);
   assign done        = busy && (ready || timeout_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_q <= arb_grant;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  state  <= IDLE;
                  last_q <= grant_q;
               end else if (cnt != '1) begin
                  // Saturate so an unbounded wait (TIMEOUT=0) can never wrap.
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_comb begin
      s_valid = busy;
      address = '0;
      wdata   = '0;
      write   = 1'b0;
      wstrb   = '0;
      m_ready = '0;
      m_err   = '0;
      m_rdata = '0;
      if (busy) begin
         address = m_address[grant_q];
         wdata   = m_wdata[grant_q];
         write   = m_write[grant_q];
         wstrb   = m_wstrb[grant_q];
      end
      // ready beats a coincident timeout.
      if (done) begin
         m_ready[grant_q] = 1'b1;
         m_err[grant_q]   = !ready;
         m_rdata[grant_q] = ready ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_morv_bus_arbiter.sv
// Directed scenarios for morv_bus_arbiter with a latency-programmable memory model and a completion scoreboard.
module tb_morv_bus_arbiter;

   localparam logic [31:0] K = 32'hA5A5_A5A5;

   typedef struct {
      int          mst;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } cpl_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
      logic [3:0]  wstrb;
   } bus_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       m_req;
   logic [1:0][31:0] m_address;
   logic [1:0][31:0] m_wdata;
   logic [1:0]       m_write;
   logic [1:0][3:0]  m_wstrb;
   logic [1:0][31:0] m_rdata;
   logic [1:0]       m_ready;
   logic [1:0]       m_err;
   logic             s_valid;
   logic [31:0]      address;
   logic [31:0]      wdata;
   logic             write;
   logic [3:0]       wstrb;
   logic [31:0]      rdata;
   logic             ready;

   int          mem_lat;
   logic        mem_fixed;
   logic [31:0] mem_rdata;
   logic        force_ready;
   int          bcnt;

   cpl_t exp_q[$];
   cpl_t obs_q[$];
   bus_t bus_q[$];
   int   cyc;
   int   sv_cycles;
   int   viol;
   int   n_cmp;
   int   n_bad;

   morv_bus_arbiter #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .m_req     (m_req),
      .m_address (m_address),
      .m_wdata   (m_wdata),
      .m_write   (m_write),
      .m_wstrb   (m_wstrb),
      .m_rdata   (m_rdata),
      .m_ready   (m_ready),
      .m_err     (m_err),
      .s_valid   (s_valid),
      .address   (address),
      .wdata     (wdata),
      .write     (write),
      .wstrb     (wstrb),
      .rdata     (rdata),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   // Memory model: ready on the mem_lat-th BUSY cycle (0 = never).
   assign ready = force_ready | ((mem_lat != 0) && s_valid && (bcnt == mem_lat - 1));
   assign rdata = mem_fixed ? mem_rdata : (address ^ K);

   always @(posedge clk or posedge rst) begin
      if (rst)
         bcnt <= 0;
      else if (s_valid && !(|m_ready))
         bcnt <= bcnt + 1;
      else
         bcnt <= 0;
   end

   initial begin
      cyc = 0;
      sv_cycles = 0;
      viol = 0;
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (s_valid) begin
         sv_cycles <= sv_cycles + 1;
         bus_q.push_back('{addr: address, wdata: wdata, write: write, wstrb: wstrb});
      end else if (address != 0 || wdata != 0 || write != 0 || wstrb != 0) begin
         viol <= viol + 1;
      end
      if (m_ready == 2'b11)
         viol <= viol + 1;
      else if (|m_ready)
         obs_q.push_back('{mst: m_ready[1] ? 1 : 0, rdata: m_rdata[m_ready[1]],
                           err: m_err[m_ready[1]], cyc: cyc});
      for (int i = 0; i < 2; i++)
         if (!m_ready[i] && (m_rdata[i] != 0 || m_err[i] != 0))
            viol <= viol + 1;
   end

   task automatic wait_obs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid got=%b want=0", s_valid); end
      n_cmp++;
      if (m_ready !== 2'b00 || m_err !== 2'b00) begin
         n_bad++; $display("FAIL reset_m_ready got=%b/%b want=00/00", m_ready, m_err);
      end
      n_cmp++;
      if (address !== 32'h0 || m_rdata !== 64'h0) begin
         n_bad++; $display("FAIL reset_bus got addr=%h rdata=%h want=0", address, m_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      cpl_t e, o;
      bit   ok;
      int   sv0;
      mem_lat = 2; mem_fixed = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      sv0 = sv_cycles;
      m_address[0] = 32'h100; m_write[0] = 1'b0;
      m_req = 2'b01;
      exp_q.push_back('{mst: 0, rdata: 32'hDEAD_BEEF, err: 1'b0, cyc: 0});
      wait_obs(1, 50, ok);
      @(posedge clk); #1;
      m_req = 2'b00;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL read_done got=timeout want=m_ready"); end
      else begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o.mst !== e.mst || o.err !== e.err) begin
            n_bad++; $display("FAIL read_master got=%0d/err%b want=%0d/err%b", o.mst, o.err, e.mst, e.err);
         end
         n_cmp++;
         if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL read_rdata got=%h want=%h", o.rdata, e.rdata); end
      end
      n_cmp++;
      if (sv_cycles - sv0 !== 2) begin n_bad++; $display("FAIL read_busy_cycles got=%0d want=2", sv_cycles - sv0); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_contention();
      cpl_t e, o;
      bit   ok;
      int   prev;
      int   sv0;
      mem_lat = 1; mem_fixed = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      m_address[0] = 32'h0000_1000; m_address[1] = 32'h0000_2000;
      m_write = 2'b00;
      sv0 = sv_cycles;
      m_req = 2'b11;
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{mst: k % 2, rdata: m_address[k % 2] ^ K, err: 1'b0, cyc: 0});
      wait_obs(4, 60, ok);
      @(posedge clk); #1;
      m_req = 2'b00;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL cont_done got=%0d cpl want=4", obs_q.size()); end
      else begin
         prev = -1;
         for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.mst !== e.mst || o.rdata !== e.rdata || o.err !== e.err) begin
               n_bad++;
               $display("FAIL cont_grant%0d got=m%0d/%h/%b want=m%0d/%h/%b", k, o.mst, o.rdata, o.err,
                        e.mst, e.rdata, e.err);
            end
            if (k > 0) begin
               n_cmp++;
               if (o.cyc - prev !== 2) begin n_bad++; $display("FAIL cont_gap%0d got=%0d want=2", k, o.cyc - prev); end
            end
            prev = o.cyc;
         end
      end
      n_cmp++;
      if (sv_cycles - sv0 !== 4) begin n_bad++; $display("FAIL cont_busy_cycles got=%0d want=4", sv_cycles - sv0); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write();
      cpl_t e, o;
      bit   ok;
      int   bad;
      mem_lat = 3; mem_fixed = 1'b0;
      @(posedge clk); #1;
      m_address[0] = 32'hFFFF_0000; m_wdata[0] = 32'hCAFE_F00D; m_wstrb[0] = 4'b1111; m_write[0] = 1'b0;
      m_address[1] = 32'h20; m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'b0011; m_write[1] = 1'b1;
      bus_q.delete();
      m_req = 2'b10;
      exp_q.push_back('{mst: 1, rdata: 32'h20 ^ K, err: 1'b0, cyc: 0});
      wait_obs(1, 50, ok);
      @(posedge clk); #1;
      m_req = 2'b00; m_write = 2'b00;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL write_done got=timeout want=m_ready[1]"); end
      else begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o.mst !== e.mst || o.err !== e.err || o.rdata !== e.rdata) begin
            n_bad++; $display("FAIL write_cpl got=m%0d/%b/%h want=m%0d/%b/%h", o.mst, o.err, o.rdata, e.mst, e.err, e.rdata);
         end
      end
      bad = 0;
      foreach (bus_q[i])
         if (bus_q[i].addr !== 32'h20 || bus_q[i].wdata !== 32'h1234_5678 || bus_q[i].write !== 1'b1 ||
             bus_q[i].wstrb !== 4'b0011)
            bad++;
      n_cmp++;
      if (bad !== 0 || bus_q.size() !== 3) begin
         n_bad++; $display("FAIL write_bus got=%0d bad of %0d cycles want=0 of 3", bad, bus_q.size());
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_timeout();
      cpl_t e, o;
      bit   ok;
      int   sv0;
      for (int run = 0; run < 2; run++) begin
         mem_lat = (run == 0) ? 0 : 16; mem_fixed = 1'b0;
         @(posedge clk); #1;
         sv0 = sv_cycles;
         m_address[0] = 32'h40; m_write[0] = 1'b0;
         m_req = 2'b01;
         exp_q.push_back('{mst: 0, rdata: (run == 0) ? 32'h0 : (32'h40 ^ K), err: (run == 0), cyc: 0});
         wait_obs(1, 60, ok);
         @(posedge clk); #1;
         m_req = 2'b00;
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL timeout%0d_done got=timeout want=m_ready", run); end
         else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.mst !== e.mst || o.err !== e.err || o.rdata !== e.rdata) begin
               n_bad++;
               $display("FAIL timeout%0d_cpl got=m%0d/err%b/%h want=m%0d/err%b/%h", run, o.mst, o.err, o.rdata,
                        e.mst, e.err, e.rdata);
            end
         end
         n_cmp++;
         if (sv_cycles - sv0 !== 16) begin
            n_bad++; $display("FAIL timeout%0d_busy_cycles got=%0d want=16", run, sv_cycles - sv0);
         end
         @(negedge clk);
         n_cmp++;
         if (s_valid !== 1'b0) begin n_bad++; $display("FAIL timeout%0d_idle got=%b want=0", run, s_valid); end
         repeat (2) @(posedge clk);
      end
   endtask

   task automatic test_ready_in_idle();
      int n0;
      n0 = obs_q.size();
      @(posedge clk); #1;
      force_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      force_ready = 1'b0;
      n_cmp++;
      if (obs_q.size() !== n0) begin n_bad++; $display("FAIL idle_ready got=%0d cpl want=%0d", obs_q.size(), n0); end
   endtask

   task automatic test_reset_mid();
      cpl_t e, o;
      bit   ok;
      int   sv0;
      mem_lat = 0; mem_fixed = 1'b0;
      @(posedge clk); #1;
      m_address[0] = 32'h80; m_write[0] = 1'b0;
      m_req = 2'b01;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy got=%b want=1", s_valid); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (s_valid !== 1'b0 || m_ready !== 2'b00) begin
         n_bad++; $display("FAIL rstmid_async got=%b/%b want=0/00", s_valid, m_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      mem_lat = 2;
      sv0 = sv_cycles;
      @(posedge clk); #1;
      n_cmp++;
      if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_regrant got=%b want=1", s_valid); end
      n_cmp++;
      if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse got=%0d cpl want=0", obs_q.size()); end
      exp_q.push_back('{mst: 0, rdata: 32'h80 ^ K, err: 1'b0, cyc: 0});
      wait_obs(1, 50, ok);
      @(posedge clk); #1;
      m_req = 2'b00;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rstmid_done got=timeout want=m_ready"); end
      else begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o.mst !== e.mst || o.err !== e.err || o.rdata !== e.rdata) begin
            n_bad++; $display("FAIL rstmid_cpl got=m%0d/%b/%h want=m%0d/%b/%h", o.mst, o.err, o.rdata, e.mst, e.err, e.rdata);
         end
         n_cmp++;
         if (sv_cycles - sv0 !== 2) begin n_bad++; $display("FAIL rstmid_busy_cycles got=%0d want=2", sv_cycles - sv0); end
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_invariants();
      n_cmp++;
      if (viol !== 0) begin n_bad++; $display("FAIL invariants got=%0d violations want=0", viol); end
      n_cmp++;
      if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
         n_bad++; $display("FAIL leftover got=obs%0d/exp%0d want=0/0", obs_q.size(), exp_q.size());
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1;
      m_req = '0; m_address = '0; m_wdata = '0; m_write = '0; m_wstrb = '0;
      mem_lat = 0; mem_fixed = 1'b0; mem_rdata = '0; force_ready = 1'b0;
      test_reset();
      test_single_read();
      test_contention();
      test_write();
      test_timeout();
      test_ready_in_idle();
      test_reset_mid();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
